// File: rtl/s3g_tx_sched.sv
// s3g_tx_sched: round-robin arbiter sharing one s3g_tx packet transmitter among N_REQ sources.
// Latency: grant/sel one cycle after a request is seen in IDLE; packet_wr one cycle after grant.
// Backpressure: no grant while tx_busy is high in IDLE; a source holds req until its done or err.
// Build option: define S3G_TX_SCHED_PRIO0_EN to give requester 0 strict priority over the rotation.
module s3g_tx_sched #(
    parameter int N_REQ         = 4,
    parameter int SEL_W         = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             packet_wr,
    input  logic             tx_busy,
    output logic [N_REQ-1:0] done,
    output logic             err,
    output logic             active
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]       TO_LAST  = 8'(START_TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

`ifdef S3G_TX_SCHED_PRIO0_EN
    localparam bit PRIO0_EN = 1'b1;
`else
    localparam bit PRIO0_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ARM, WAIT_START, WAIT_END, GAP} state_t;

    // With no gap configured the block returns straight to IDLE after a packet.
    localparam state_t POST_PKT = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, ptr_nxt;
    logic [7:0]         tcnt, tcnt_nxt;
    logic [GAP_W-1:0]   gcnt, gcnt_nxt;
    logic [N_REQ-1:0]   grant_nxt, done_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               wr_nxt, err_nxt;

    logic               win_vld, win_upd;
    logic [N_REQ-1:0]   win_oh, cand_oh;
    logic [SEL_W-1:0]   win_sel, win_ptr;
    int                 cand;

    // Winner search: first set request at or after the pointer, wrapping; optional req[0] override.
    always_comb begin
        win_vld = 1'b0;
        win_upd = 1'b1;
        win_oh  = '0;
        win_sel = '0;
        win_ptr = rr_ptr;
        cand    = 0;
        cand_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand    = (int'(rr_ptr) + i) % N_REQ;
            cand_oh = ONE << cand;
            if (!win_vld && ((req & cand_oh) != '0)) begin
                win_vld = 1'b1;
                win_oh  = cand_oh;
                win_sel = SEL_W'(cand);
                win_ptr = SEL_W'((cand + 1) % N_REQ);
            end
        end
        // Requester 0 preempts the rotation and leaves the pointer untouched, so 1..N-1 keep their order.
        if (PRIO0_EN && req[0]) begin
            win_vld = 1'b1;
            win_upd = 1'b0;
            win_oh  = ONE;
            win_sel = '0;
        end
    end

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        wr_nxt    = 1'b0;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        tcnt_nxt  = tcnt;
        gcnt_nxt  = gcnt;
        ptr_nxt   = rr_ptr;
        case (state)
            IDLE: begin
                // A high tx_busy here means someone else (or a stale packet) owns the transmitter.
                if (win_vld && !tx_busy) begin
                    grant_nxt = win_oh;
                    sel_nxt   = win_sel;
                    if (win_upd) begin
                        ptr_nxt = win_ptr;
                    end
                    state_nxt = ARM;
                end
            end
            ARM: begin
                // grant/sel have been stable for a cycle, so the mux output is valid when s3g_tx latches.
                wr_nxt    = 1'b1;
                tcnt_nxt  = '0;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_nxt = WAIT_END;
                end else if (tcnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    grant_nxt = '0;
                    sel_nxt   = '0;
                    gcnt_nxt  = '0;
                    state_nxt = POST_PKT;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end
            WAIT_END: begin
                // No timeout: a long payload may keep the transmitter busy indefinitely.
                if (!tx_busy) begin
                    done_nxt  = grant;
                    grant_nxt = '0;
                    sel_nxt   = '0;
                    gcnt_nxt  = '0;
                    state_nxt = POST_PKT;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, pointer and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            tcnt      <= '0;
            gcnt      <= '0;
            grant     <= '0;
            sel       <= '0;
            packet_wr <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= ptr_nxt;
            tcnt      <= tcnt_nxt;
            gcnt      <= gcnt_nxt;
            grant     <= grant_nxt;
            sel       <= sel_nxt;
            packet_wr <= wr_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            active    <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/s3g_tx_sched.md
Name: s3g_tx_sched

Overview:
Round-robin scheduler that shares one S3G packet transmitter (s3g_tx) among N_REQ packet sources. It grants one requester at a time and drives the select of the external payload/length mux. It issues the single-cycle packet_wr strobe, then tracks the transmitter's busy flag until the packet is finished. Per-requester done pulses, an inter-packet gap, and a start-timeout error complete the block.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEL_W, 2, width of sel; must satisfy 2**SEL_W >= N_REQ
GAP_CYCLES, 2, idle cycles forced after each packet or error (0 = none)
START_TIMEOUT, 15, cycles to wait for tx_busy rise after packet_wr before flagging error (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  level request per source; held until matching done or err
grant  out  N_REQ  one-hot owner of transmitter; 0 when none
sel  out  SEL_W  index of granted source, drives payload/len mux
packet_wr  out  1  one-cycle strobe to s3g_tx
tx_busy  in  1  busy from s3g_tx
done  out  N_REQ  one-cycle pulse to owner when packet fully sent
err  out  1  one-cycle pulse on start timeout
active  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): grant=0, sel=0, packet_wr=0, done=0, err=0, active=0, state=IDLE, rr pointer=0, counters=0.
- All outputs are registered.
- States: IDLE, ARM, WAIT_START, WAIT_END, GAP.
- IDLE: if req!=0 and tx_busy=0, choose a winner, register grant/sel, go ARM. If tx_busy=1 (foreign or stale use), no grant.
- Arbitration: search starts at the rr pointer and wraps modulo N_REQ; first set req wins. The pointer becomes winner+1 (mod N_REQ) when the grant registers.
- ARM: packet_wr=1 for exactly this cycle. sel/grant are stable from the cycle before, so s3g_tx latches the correct buffer. Next state is WAIT_START with timeout counter=0.
- WAIT_START: when tx_busy=1, go WAIT_END. Otherwise increment the counter. At counter==START_TIMEOUT-1 with tx_busy=0: err=1 for one cycle, grant/sel cleared, no done pulse, go GAP.
- WAIT_END: when tx_busy=0, pulse done[winner] for one cycle, clear grant and sel, go GAP. There is no timeout in this state; a packet of 0..255 payload bytes takes arbitrarily long.
- GAP: count GAP_CYCLES cycles, then go IDLE. With GAP_CYCLES=0, go directly to IDLE. This state also gives the requester a cycle to drop req after done.
- A req dropped while its owner is granted is ignored; the transaction completes and done still pulses.
- A req that is still asserted after done is treated as a new request and waits its round-robin turn.
- Simultaneous requests: exactly one grant per transaction; grant is never multi-hot.
- Reset mid-packet: outputs are forced to reset values immediately and no done is issued. The owner must re-request after reset.
- Width rules: the timeout counter is 8 bits; the gap counter is ceil(log2(GAP_CYCLES+1)) bits, minimum 1.

Optional Feature:
S3G_TX_SCHED_PRIO0_EN
- Defined: requester 0 has strict priority. If req[0]=1 in IDLE it wins regardless of the pointer, and the pointer is not updated. Requesters 1..N_REQ-1 rotate round-robin among themselves.
- Undefined: pure round-robin across all N_REQ requesters, requester 0 included.

Test Plan:
- Single request: req=0001, modelled tx_busy high 1 cycle after packet_wr for 20 cycles -> grant=0001 and sel=0; packet_wr one cycle later; done[0] one cycle after busy falls; GAP for 2 cycles; active=0 afterwards.
- Contention: req=1011 held continuously from reset -> grant order 0,1,3,0,1,3. Exactly one packet_wr per grant, each grant separated by at least 2 GAP cycles.
- Timeout: req=0100, tx_busy held 0 -> err pulses on the 15th cycle after packet_wr; done stays 0; grant clears; next grant is issued after the gap.
- Busy in IDLE: tx_busy=1 with req=0010 -> no grant until tx_busy=0; grant follows the cycle after it falls.
- Reset mid-packet: assert rst=0 during WAIT_END -> all outputs 0 asynchronously. After release with req=0001, a fresh grant is issued and no stale done appears.
- PRIO0 (macro defined): req=0111 held -> grants 0,0,0 while req[0] stays high. After req[0] drops, grants alternate 1,2.
